// File: rtl/vx_issue_arbiter.sv
// Round-robin issue arbiter: grants one warp per cycle into a 2-entry elastic
// output buffer (1-cycle latency, full throughput) and counts input stalls.
module vx_issue_arbiter #(
    parameter int unsigned  NUM_REQS      = 4,
    parameter int unsigned  DATAW         = 64,
    parameter int unsigned  PERF_CTR_BITS = 44,
    localparam int unsigned IDXW          = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         valid_in,
    input  logic [NUM_REQS*DATAW-1:0]   data_in,
    output logic [NUM_REQS-1:0]         ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    output logic [IDXW-1:0]             sel_out,
    input  logic                        ready_out,
    output logic [PERF_CTR_BITS-1:0]    perf_stalls
);

    logic [1:0]               count_q, count_d;
    logic [IDXW-1:0]          last_q;
    logic [PERF_CTR_BITS-1:0] perf_q;
    logic [DATAW-1:0]         head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [IDXW-1:0]          head_idx_q, head_idx_d, skid_idx_q, skid_idx_d;

    logic [IDXW-1:0]          cand;
    logic [IDXW-1:0]          grant_idx;
    logic                     grant_valid;
    logic                     space;
    logic                     push;
    logic                     pop;
    logic [DATAW-1:0]         win_data;

    // Rotating-priority search starting just after the last granted requester
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            cand = IDXW'((32'(last_q) + 32'd1 + i) % NUM_REQS);
            if (!grant_valid && valid_in[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // space is purely registered, so ready_in never sees ready_out
    assign space     = (count_q != 2'd2);
    assign push      = grant_valid & space & ~reset;
    assign ready_in  = push ? (NUM_REQS'(1) << grant_idx) : '0;
    assign valid_out = (count_q != 2'd0) & ~reset;
    assign pop       = valid_out & ready_out;
    assign data_out  = head_data_q;
    assign sel_out   = head_idx_q;
    assign perf_stalls = perf_q;
    assign win_data  = data_in[32'(grant_idx) * DATAW +: DATAW];

    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_idx_d  = head_idx_q;
        skid_data_d = skid_data_q;
        skid_idx_d  = skid_idx_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_data_d = win_data;
                    head_idx_d  = grant_idx;
                    count_d     = 2'd1;
                end
            end
            2'd1: begin
                if (push && !pop) begin
                    skid_data_d = win_data;
                    skid_idx_d  = grant_idx;
                    count_d     = 2'd2;
                end else if (pop && !push) begin
                    count_d     = 2'd0;
                end else if (push && pop) begin
                    head_data_d = win_data;
                    head_idx_d  = grant_idx;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_data_d = skid_data_q;
                    head_idx_d  = skid_idx_q;
                    count_d     = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            last_q  <= IDXW'(NUM_REQS - 1);
            perf_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                last_q <= grant_idx;
            end
            if ((|valid_in) && !space) begin
                perf_q <= perf_q + PERF_CTR_BITS'(1);
            end
        end
    end

    // Payload registers carry no reset; valid_out qualifies them
    always_ff @(posedge clk) begin
        head_data_q <= head_data_d;
        head_idx_q  <= head_idx_d;
        skid_data_q <= skid_data_d;
        skid_idx_q  <= skid_idx_d;
    end

endmodule

// File: tb/tb_vx_issue_arbiter.sv
// Bench for vx_issue_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expected grant/output orders.
module tb_vx_issue_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int PB = 44;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      valid_in;
    logic [N*DW-1:0]   data_in;
    logic [N-1:0]      ready_in;
    logic              valid_out;
    logic [DW-1:0]     data_out;
    logic [IW-1:0]     sel_out;
    logic              ready_out;
    logic [PB-1:0]     perf_stalls;

    vx_issue_arbiter #(.NUM_REQS(N), .DATAW(DW), .PERF_CTR_BITS(PB)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
        .sel_out(sel_out), .ready_out(ready_out), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered queue of accepted (index, payload), capacity 2
    int              m_q_sel[$];
    logic [DW-1:0]   m_q_data[$];
    int              m_last   = N - 1;
    logic [PB-1:0]   m_stalls = '0;
    bit              m_init   = 1'b0;
    bit              m_push   = 1'b0;
    bit              m_pop    = 1'b0;
    bit              m_stall  = 1'b0;
    int              m_push_idx = 0;

    int dut_grants[$];
    int dut_outs[$];

    // Payload stamps change every cycle so stale or misrouted data is visible
    int stamp = 0;
    always @(posedge clk) begin
        #1;
        stamp++;
        for (int i = 0; i < N; i++)
            data_in[i*DW +: DW] = {16'(i + 1), 48'(stamp)};
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] exp_ready;
        int found;
        if (m_init) begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (found < 0 && valid_in[c]) found = c;
            end
            exp_ready = '0;
            m_push    = 1'b0;
            if (!reset && m_q_sel.size() < 2 && found >= 0) begin
                exp_ready[found] = 1'b1;
                m_push     = 1'b1;
                m_push_idx = found;
            end
            m_pop   = !reset && m_q_sel.size() > 0 && ready_out;
            m_stall = (|valid_in) && m_q_sel.size() >= 2;
            check("ready_in", 64'(ready_in), 64'(exp_ready));
            check("valid_out", 64'(valid_out), 64'(!reset && m_q_sel.size() > 0));
            if (!reset && m_q_sel.size() > 0) begin
                check("sel_out", 64'(sel_out), 64'(m_q_sel[0]));
                check("data_out", data_out, m_q_data[0]);
            end
            check("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
            for (int i = 0; i < N; i++)
                if (ready_in[i]) dut_grants.push_back(i);
            if (valid_out && ready_out && !reset) dut_outs.push_back(int'(sel_out));
        end
    end

    always @(posedge clk) begin : model
        if (reset) begin
            m_q_sel.delete();
            m_q_data.delete();
            m_last   = N - 1;
            m_stalls = '0;
            m_init   = 1'b1;
        end else if (m_init) begin
            if (m_pop) begin
                void'(m_q_sel.pop_front());
                void'(m_q_data.pop_front());
            end
            if (m_push) begin
                m_q_sel.push_back(m_push_idx);
                m_q_data.push_back(data_in[m_push_idx*DW +: DW]);
                m_last = m_push_idx;
            end
            if (m_stall) m_stalls = m_stalls + 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        dut_grants.delete();
        dut_outs.delete();
    endtask

    initial begin
        int exp_g2[5] = '{0, 1, 2, 3, 0};
        int exp_g5[5] = '{0, 2, 0, 2, 0};
        reset = 1'b1; valid_in = '0; ready_out = 1'b0; data_in = '0;
        cyc(2);
        reset = 1'b0;

        // Idle after reset
        cyc(5); #3;
        check("idle_valid_out", 64'(valid_out), 64'd0);
        check("idle_ready_in", 64'(ready_in), 64'd0);
        check("idle_perf", 64'(perf_stalls), 64'd0);

        // All requesting, downstream always ready
        clear_logs();
        valid_in = 4'b1111; ready_out = 1'b1;
        cyc(5);
        valid_in = '0;
        cyc(2); #3;
        check("rr_grant_count", 64'(dut_grants.size()), 64'd5);
        check("rr_out_count", 64'(dut_outs.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("rr_grant_order", 64'(dut_grants[i]), 64'(exp_g2[i]));
            check("rr_out_order", 64'(dut_outs[i]), 64'(exp_g2[i]));
        end

        reset = 1'b1; cyc(1); reset = 1'b0;

        // All requesting, downstream blocked then released
        clear_logs();
        valid_in = 4'b1111; ready_out = 1'b0;
        cyc(6); #3;
        check("bp_grant_count", 64'(dut_grants.size()), 64'd2);
        check("bp_grant0", 64'(dut_grants[0]), 64'd0);
        check("bp_grant1", 64'(dut_grants[1]), 64'd1);
        check("bp_ready_in", 64'(ready_in), 64'd0);
        check("bp_perf", 64'(perf_stalls), 64'd4);
        ready_out = 1'b1;
        cyc(2);
        valid_in = '0;
        cyc(1); #3;
        check("bp_perf_after", 64'(perf_stalls), 64'd5);
        check("bp_next_grant", 64'(dut_grants.size() == 3 ? dut_grants[2] : -1), 64'd2);
        check("bp_out_count", 64'(dut_outs.size()), 64'd3);
        check("bp_out0", 64'(dut_outs[0]), 64'd0);
        check("bp_out1", 64'(dut_outs[1]), 64'd1);

        // Lone requester 2
        clear_logs();
        valid_in = 4'b0100; ready_out = 1'b1;
        cyc(6);
        valid_in = '0;
        cyc(2); #3;
        check("lone_grant_count", 64'(dut_grants.size()), 64'd6);
        check("lone_out_count", 64'(dut_outs.size()), 64'd6);
        foreach (dut_grants[i]) check("lone_grant_idx", 64'(dut_grants[i]), 64'd2);
        foreach (dut_outs[i]) check("lone_out_idx", 64'(dut_outs[i]), 64'd2);

        // Toggling downstream ready with requesters 0 and 2
        clear_logs();
        valid_in = 4'b0101; ready_out = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (dut_grants.size() >= 5) break;
            ready_out = ~ready_out;
            cyc(1);
        end
        valid_in = '0; ready_out = 1'b1;
        cyc(4); #3;
        check("tog_grant_count", 64'(dut_grants.size()), 64'd5);
        check("tog_out_count", 64'(dut_outs.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("tog_grant_order", 64'(dut_grants[i]), 64'(exp_g5[i]));
            check("tog_out_vs_accept", 64'(dut_outs[i]), 64'(dut_grants[i]));
        end

        // Reset while the buffer is full
        valid_in = 4'b1111; ready_out = 1'b0;
        cyc(3);
        reset = 1'b1; #3;
        check("rst_cycle_ready_in", 64'(ready_in), 64'd0);
        check("rst_cycle_valid_out", 64'(valid_out), 64'd0);
        cyc(1);
        reset = 1'b0; ready_out = 1'b1; #3;
        check("post_rst_valid_out", 64'(valid_out), 64'd0);
        check("post_rst_ready_in", 64'(ready_in), 64'b0001);
        cyc(1); #3;
        check("post_rst_first_out_valid", 64'(valid_out), 64'd1);
        check("post_rst_first_out_sel", 64'(sel_out), 64'd0);
        valid_in = '0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
